// File: rtl/fmps_arb_pkg.sv
// Shared types and helpers for the FMPS packet arbiter family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fmps_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FWD   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int          FMPS_DATA_WIDTH      = 32;
  localparam logic [15:0] DEFAULT_HEADER_MAGIC = 16'hB6CF;

  // Increment that sticks at the all-ones value of a 'width'-bit counter
  // (width up to 32); callers truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

endpackage

// File: rtl/fmps_rr_select.sv
// Rotate-priority encoder: first set request at or above ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; req is sampled as presented.
// Ports: req (one bit per requester), ptr (search start), found, index.
module fmps_rr_select #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               found,
  output logic [IDX_W-1:0]   index
);

  always_comb begin
    int idx;
    found = 1'b0;
    index = '0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        index = IDX_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fmps_packet_arbiter.sv
// Packet-granular round-robin merge of NUM_SOURCES AXI streams onto one Aurora TX stream.
// Latency: one idle decision cycle per packet, then zero-latency passthrough at 1 beat/cycle.
// Backpressure: txTready passes straight to the granted source; malformed/aborted packets are sunk.
// Ports: auroraUserClk/auroraUserRstN clock and async active-low reset; auroraFAstrobe session start;
//        auroraChannelUp link status; srcT* per-source streams; txT* merged stream;
//        grantIndex/busy/sessionPktCount/badHeaderCount/abortCount status.
module fmps_packet_arbiter
  import fmps_arb_pkg::*;
#(
  parameter  int          NUM_SOURCES  = 4,
  parameter  logic [15:0] HEADER_MAGIC = DEFAULT_HEADER_MAGIC,
  parameter  int          CNT_WIDTH    = 16,
  localparam int          IDX_W        = $clog2(NUM_SOURCES)
) (
  input  logic                                   auroraUserClk,
  input  logic                                   auroraUserRstN,
  input  logic                                   auroraFAstrobe,
  input  logic                                   auroraChannelUp,
  input  logic [FMPS_DATA_WIDTH*NUM_SOURCES-1:0] srcTdata,
  input  logic [NUM_SOURCES-1:0]                 srcTvalid,
  input  logic [NUM_SOURCES-1:0]                 srcTlast,
  output logic [NUM_SOURCES-1:0]                 srcTready,
  output logic [FMPS_DATA_WIDTH-1:0]             txTdata,
  output logic                                   txTvalid,
  output logic                                   txTlast,
  input  logic                                   txTready,
  output logic [IDX_W-1:0]                       grantIndex,
  output logic                                   busy,
  output logic [CNT_WIDTH-1:0]                   sessionPktCount,
  output logic [CNT_WIDTH-1:0]                   badHeaderCount,
  output logic [CNT_WIDTH-1:0]                   abortCount
);

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]     grant_q, grant_d;
  logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_WIDTH-1:0] session_q, session_d;
  logic [CNT_WIDTH-1:0] bad_q, bad_d;
  logic [CNT_WIDTH-1:0] abort_q, abort_d;

  logic                       cand_found;
  logic [IDX_W-1:0]           cand_idx;
  logic [15:0]                cand_magic;
  logic [FMPS_DATA_WIDTH-1:0] g_dat;
  logic                       g_vld;
  logic                       g_last;
  logic                       pkt_done;

  function automatic logic [CNT_WIDTH-1:0] cnt_inc(input logic [CNT_WIDTH-1:0] v);
    return CNT_WIDTH'(sat_inc(32'(v), CNT_WIDTH));
  endfunction

  fmps_rr_select #(.NUM_REQ(NUM_SOURCES)) u_rr_select (
    .req   (srcTvalid),
    .ptr   (rr_ptr_q),
    .found (cand_found),
    .index (cand_idx)
  );

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    run_cnt_d = run_cnt_q;
    session_d = session_q;
    bad_d     = bad_q;
    abort_d   = abort_q;
    pkt_done  = 1'b0;
    srcTready = '0;
    txTdata   = '0;
    txTvalid  = 1'b0;
    txTlast   = 1'b0;

    cand_magic = srcTdata[FMPS_DATA_WIDTH*int'(cand_idx) + 16 +: 16];
    g_dat      = srcTdata[FMPS_DATA_WIDTH*int'(grant_q) +: FMPS_DATA_WIDTH];
    g_vld      = srcTvalid[grant_q];
    g_last     = srcTlast[grant_q];

    unique case (state_q)
      ST_IDLE: begin
        // Decide on the head beat only; nothing is consumed until the next cycle.
        if (auroraChannelUp && cand_found) begin
          grant_d  = cand_idx;
          rr_ptr_d = (cand_idx == IDX_W'(NUM_SOURCES - 1)) ? '0 : cand_idx + 1'b1;
          if (cand_magic == HEADER_MAGIC) begin
            state_d = ST_FWD;
          end else begin
            state_d = ST_DRAIN;
            bad_d   = cnt_inc(bad_q);
          end
        end
      end
      ST_FWD: begin
        // Link loss gates the stream in the same cycle so no beat is offered
        // to a dead channel; the rest of the packet is sunk in DRAIN.
        if (!auroraChannelUp) begin
          abort_d = cnt_inc(abort_q);
          state_d = ST_DRAIN;
        end else begin
          txTdata            = g_dat;
          txTvalid           = g_vld;
          txTlast            = g_last;
          srcTready[grant_q] = txTready;
          if (g_vld && txTready && g_last) begin
            pkt_done = 1'b1;
            state_d  = ST_IDLE;
          end
        end
      end
      ST_DRAIN: begin
        srcTready[grant_q] = 1'b1;
        if (g_vld && g_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (pkt_done) run_cnt_d = cnt_inc(run_cnt_q);

    // A packet finishing on the strobe cycle lands in both the closed
    // session snapshot and the new session's running count.
    if (auroraFAstrobe) begin
      session_d = run_cnt_d;
      run_cnt_d = pkt_done ? CNT_WIDTH'(1) : '0;
      rr_ptr_d  = '0;
    end
  end

  always_ff @(posedge auroraUserClk or negedge auroraUserRstN) begin
    if (!auroraUserRstN) begin
      state_q   <= ST_IDLE;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      run_cnt_q <= '0;
      session_q <= '0;
      bad_q     <= '0;
      abort_q   <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      run_cnt_q <= run_cnt_d;
      session_q <= session_d;
      bad_q     <= bad_d;
      abort_q   <= abort_d;
    end
  end

  assign grantIndex      = grant_q;
  assign busy            = (state_q != ST_IDLE);
  assign sessionPktCount = session_q;
  assign badHeaderCount  = bad_q;
  assign abortCount      = abort_q;

endmodule

// File: tb/tb_fmps_packet_arbiter.sv
// Bench for fmps_packet_arbiter: per-source beat queues drive the sources, a
// scoreboard holds the expected packet order, and a per-cycle checker compares
// the merged stream with the granted source's head beat.
module tb_fmps_packet_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst_n, fa, chup, txTready;
  logic [32*N-1:0] srcTdata;
  logic [N-1:0]  srcTvalid, srcTlast, srcTready;
  logic [31:0]   txTdata;
  logic          txTvalid, txTlast, busy;
  logic [1:0]    grantIndex;
  logic [15:0]   sess_cnt, bad_cnt, abort_cnt;

  always #5 clk = ~clk;

  fmps_packet_arbiter #(.NUM_SOURCES(N), .HEADER_MAGIC(16'hB6CF), .CNT_WIDTH(16)) dut (
    .auroraUserClk   (clk),
    .auroraUserRstN  (rst_n),
    .auroraFAstrobe  (fa),
    .auroraChannelUp (chup),
    .srcTdata        (srcTdata),
    .srcTvalid       (srcTvalid),
    .srcTlast        (srcTlast),
    .srcTready       (srcTready),
    .txTdata         (txTdata),
    .txTvalid        (txTvalid),
    .txTlast         (txTlast),
    .txTready        (txTready),
    .grantIndex      (grantIndex),
    .busy            (busy),
    .sessionPktCount (sess_cnt),
    .badHeaderCount  (bad_cnt),
    .abortCount      (abort_cnt)
  );

  // Source model: mem holds {last, data}; head advances only on a handshake.
  logic [32:0] mem [N][64];
  int          head [N];
  int          tail [N];
  int          exp_src[$];
  int          tests = 0;
  int          fails = 0;
  int          acc_beats = 0;
  int          drained_beats = 0;
  bit          sop = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic push(input int s, input int nbeats, input logic [15:0] hdr, input bit fwd);
    for (int b = 0; b < nbeats; b++) begin
      mem[s][tail[s]] = {(b == nbeats - 1), (b == 0) ? {hdr, 16'(tail[s])}
                                                     : {8'hA0, 8'(s), 16'(tail[s])}};
      tail[s]++;
    end
    if (fwd) exp_src.push_back(s);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic strobe();
    tick();
    fa = 1'b1;
    tick();
    fa = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (exp_src.size() == 0 && !busy && all_empty()) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s: timeout with %0d packets still expected", name, exp_src.size());
    end
  endtask

  // Source driver: present each queue head shortly after the clock edge.
  initial begin
    srcTvalid = '0;
    srcTlast  = '0;
    srcTdata  = '0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        srcTvalid[i]         = (head[i] < tail[i]);
        srcTdata[32*i +: 32] = srcTvalid[i] ? mem[i][head[i]][31:0] : 32'h0;
        srcTlast[i]          = srcTvalid[i] & mem[i][head[i]][32];
      end
    end
  end

  // Per-cycle checker on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sop = 1'b1;
      end else begin
        chk("ready_at_most_one", 32'($countones(srcTready) <= 1), 32'd1);
        if (txTvalid) begin
          int g;
          g = int'(grantIndex);
          chk("tx_has_beat", 32'(head[g] < tail[g]), 32'd1);
          chk("tx_data", txTdata, mem[g][head[g]][31:0]);
          chk("tx_last", 32'(txTlast), 32'(mem[g][head[g]][32]));
          chk("ready_mirror", 32'(srcTready), txTready ? (32'd1 << g) : 32'd0);
          chk("busy_in_fwd", 32'(busy), 32'd1);
          if (sop) chk("hdr_magic", 32'(txTdata[31:16]), 32'h0000_B6CF);
          if (txTready) begin
            acc_beats++;
            head[g]++;
            sop = txTlast;
            if (txTlast) begin
              tests++;
              if (exp_src.size() == 0) begin
                fails++;
                $display("FAIL pkt_order: got packet from src %0d, expected none", g);
              end else begin
                chk("pkt_order", 32'(g), 32'(exp_src.pop_front()));
              end
            end
          end
        end else begin
          for (int i = 0; i < N; i++) begin
            if (srcTready[i] && srcTvalid[i]) begin
              drained_beats++;
              head[i]++;
              chk("drain_src", 32'(grantIndex), 32'(i));
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vbits;
    int g_a, g_b, a0, d0, n;
    bit done;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    rst_n = 1'b0; fa = 1'b0; chup = 1'b1; txTready = 1'b1;
    repeat (3) tick();
    chk("rst_srcTready", 32'(srcTready), 32'd0);
    chk("rst_txTvalid", 32'(txTvalid), 32'd0);
    chk("rst_txTlast", 32'(txTlast), 32'd0);
    chk("rst_txTdata", txTdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grantIndex), 32'd0);
    chk("rst_counters", {sess_cnt, bad_cnt | abort_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Two 2-beat packets: 1 idle decision cycle before each, back to back.
    push(0, 2, 16'hB6CF, 1'b1);
    push(2, 2, 16'hB6CF, 1'b1);
    g_a = -1; g_b = -1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      vbits[k] = txTvalid;
      if (k == 2) g_a = int'(grantIndex);
      if (k == 5) g_b = int'(grantIndex);
    end
    chk("t1_valid_pattern", 32'(vbits), 32'h0000_006C);
    chk("t1_grant_first", 32'(g_a), 32'd0);
    chk("t1_grant_second", 32'(g_b), 32'd2);
    wait_done("t1_done");
    // Pointer now sits at 3, so src3 beats src0.
    tick();
    push(3, 2, 16'hB6CF, 1'b1);
    push(0, 2, 16'hB6CF, 1'b1);
    wait_done("t1_ptr3");

    // Round robin over all sources, session snapshots on FA strobe.
    strobe();
    chk("t2_sess_prev", 32'(sess_cnt), 32'd4);
    for (int s = 0; s < N; s++) push(s, 2, 16'hB6CF, 1'b1);
    wait_done("t2_round1");
    strobe();
    chk("t2_sess_round1", 32'(sess_cnt), 32'd4);
    for (int s = 0; s < N; s++) push(s, 2, 16'hB6CF, 1'b1);
    wait_done("t2_round2");
    tick();
    push(2, 2, 16'hB6CF, 1'b1);
    wait_done("t2_src2");
    strobe();
    chk("t2_sess_round2", 32'(sess_cnt), 32'd5);
    push(1, 2, 16'hB6CF, 1'b1);   // strobe cleared the pointer: src1 before src3
    push(3, 2, 16'hB6CF, 1'b1);
    wait_done("t2_ptr_reset");

    // Bad header is drained, next packet goes through.
    tick();
    d0 = drained_beats;
    push(1, 3, 16'hDEAD, 1'b0);
    push(2, 2, 16'hB6CF, 1'b1);
    wait_done("t3_done");
    chk("t3_drained_beats", 32'(drained_beats - d0), 32'd3);
    chk("t3_bad_count", 32'(bad_cnt), 32'd1);

    // txTready toggling during a 4-beat packet.
    tick();
    a0 = acc_beats;
    push(0, 4, 16'hB6CF, 1'b1);
    for (int k = 0; k < 12; k++) begin
      tick();
      txTready = k[0];
    end
    txTready = 1'b1;
    wait_done("t4_done");
    chk("t4_accepted_beats", 32'(acc_beats - a0), 32'd4);

    // Channel loss after beat 2 of a 5-beat packet.
    tick();
    d0 = drained_beats;
    push(1, 5, 16'hB6CF, 1'b0);
    n = 0; done = 1'b0;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (txTvalid && txTready) n++;
      if (n == 2) done = 1'b1;
    end
    chk("t5_two_beats_seen", 32'(done), 32'd1);
    tick();
    chup = 1'b0;
    repeat (6) tick();
    chk("t5_abort_count", 32'(abort_cnt), 32'd1);
    chk("t5_drained_beats", 32'(drained_beats - d0), 32'd3);
    push(2, 2, 16'hB6CF, 1'b1);
    repeat (5) tick();
    chk("t5_no_grant_busy", 32'(busy), 32'd0);
    chk("t5_no_grant_ready", 32'(srcTready), 32'd0);
    chk("t5_no_grant_valid", 32'(txTvalid), 32'd0);
    chup = 1'b1;
    wait_done("t5_resume");
    strobe();
    chk("t5_sess_excl_drops", 32'(sess_cnt), 32'd5);

    // Async reset in the middle of a forwarded packet.
    tick();
    push(3, 4, 16'hB6CF, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clk);
      if (txTvalid) done = 1'b1;
    end
    chk("t6_fwd_started", 32'(done), 32'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(srcTready), 32'd0);
    chk("t6_rst_valid", 32'(txTvalid), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_counters", {sess_cnt, bad_cnt | abort_cnt}, 32'd0);
    for (int i = 0; i < N; i++) tail[i] = head[i];
    exp_src.delete();
    push(1, 2, 16'hB6CF, 1'b1);
    push(3, 2, 16'hB6CF, 1'b1);
    tick();
    rst_n = 1'b1;
    wait_done("t6_after_reset");
    chk("t6_bad_after", 32'(bad_cnt), 32'd0);
    chk("t6_abort_after", 32'(abort_cnt), 32'd0);
    chk("t6_sess_after", 32'(sess_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
